// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Turns memory waits, load-use hazards and EX-stage branch
//                redirects into hold/bubble controls for the pipeline
//                registers. A redirect raised while a fetch is in flight is
//                parked until that fetch returns; its stale response is then
//                dropped and the redirect is applied.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Iwait,
    input  logic             Dwait,
    input  logic             branch_taken_e,
    input  logic [63:0]      redirect_pc_e,
    input  logic             ld_e,
    input  logic [4:0]       dst_e,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             pc_sel,
    output logic [63:0]      redirect_pc,
    output logic             drop_ifetch,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_RWAIT  = 2'd1;
    localparam logic [1:0] c_ST_RISSUE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [63:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             w_load_use;

    // Load in EX feeding a register that ID actually reads; x0 never hazards.
    assign w_load_use = ld_e && (dst_e != 5'd0) &&
                        ((use_rs1_d && (rs1_d == dst_e)) ||
                         (use_rs2_d && (rs2_d == dst_e)));

    // State register, parked redirect target and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= c_ST_RUN;
            pend_pc_q <= RESET_PC;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            if (stall_f && (cnt_q != c_CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state: park a redirect behind an in-flight fetch, then issue it.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            c_ST_RUN: begin
                // Dwait holds EX, so the branch is re-presented later.
                if (!Dwait && branch_taken_e && Iwait) begin
                    state_d   = c_ST_RWAIT;
                    pend_pc_d = redirect_pc_e;
                end
            end
            c_ST_RWAIT: begin
                if (!Iwait) begin
                    state_d = c_ST_RISSUE;
                end
            end
            c_ST_RISSUE: begin
                if (!Dwait) begin
                    state_d = c_ST_RUN;
                end
            end
            default: begin
                state_d = c_ST_RUN;
            end
        endcase
    end

    // Output decode: stall/flush/redirect controls from state and inputs.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        pc_sel      = 1'b0;
        drop_ifetch = 1'b0;
        redirect_pc = pend_pc_q;
        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            case (state_q)
                c_ST_RUN: begin
                    if (Dwait) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                    end else if (branch_taken_e) begin
                        // Branch wins over load-use: the dependent op is flushed.
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        if (Iwait) begin
                            stall_f = 1'b1;
                        end else begin
                            pc_sel      = 1'b1;
                            redirect_pc = redirect_pc_e;
                        end
                    end else if (w_load_use || Iwait) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                c_ST_RWAIT: begin
                    stall_f     = 1'b1;
                    flush_d     = 1'b1;
                    drop_ifetch = !Iwait;
                    stall_d     = Dwait;
                    stall_e     = Dwait;
                    stall_m     = Dwait;
                end
                c_ST_RISSUE: begin
                    // stall_f stays low so the PC accepts the redirect.
                    pc_sel  = 1'b1;
                    flush_d = 1'b1;
                    stall_d = Dwait;
                    stall_e = Dwait;
                    stall_m = Dwait;
                end
                default: begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end
            endcase
        end
    end

    assign stall_cycles = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl. A second
//                instance with a 2-bit counter exercises counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Iwait, Dwait, branch_taken_e, ld_e, use_rs1_d, use_rs2_d;
    logic [63:0] redirect_pc_e;
    logic [4:0]  dst_e, rs1_d, rs2_d;

    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic        pc_sel, drop_ifetch;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cycles;

    logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e;
    logic        s_pc_sel, s_drop_ifetch;
    logic [63:0] s_redirect_pc;
    logic [1:0]  s_stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RESET_PC(64'h8000_0000), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .Iwait(Iwait), .Dwait(Dwait),
        .branch_taken_e(branch_taken_e), .redirect_pc_e(redirect_pc_e),
        .ld_e(ld_e), .dst_e(dst_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .pc_sel(pc_sel),
        .redirect_pc(redirect_pc), .drop_ifetch(drop_ifetch),
        .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.RESET_PC(64'h8000_0000), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .Iwait(Iwait), .Dwait(Dwait),
        .branch_taken_e(branch_taken_e), .redirect_pc_e(redirect_pc_e),
        .ld_e(ld_e), .dst_e(dst_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
        .flush_d(s_flush_d), .flush_e(s_flush_e), .pc_sel(s_pc_sel),
        .redirect_pc(s_redirect_pc), .drop_ifetch(s_drop_ifetch),
        .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compact compare of the seven 1-bit controls, packed as
    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_sel}.
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {57'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_sel},
            {57'd0, exp});
    endtask

    // Advance to just after the next rising edge, then let inputs be applied.
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        Iwait = 0; Dwait = 0; branch_taken_e = 0; redirect_pc_e = '0;
        ld_e = 0; dst_e = '0; rs1_d = '0; rs2_d = '0; use_rs1_d = 0; use_rs2_d = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // ---------------- reset ----------------
        next_cyc(); #1;
        chk_ctl("reset_ctl_c1", 7'b0000_110);
        chk("reset_drop", {63'd0, drop_ifetch}, 64'd0);
        next_cyc(); reset = 1'b0; #1;
        chk_ctl("post_reset_ctl", 7'b0000_000);
        chk("post_reset_cnt", {32'd0, stall_cycles}, 64'd0);
        chk("post_reset_rpc", redirect_pc, 64'h8000_0000);

        // ---------------- load-use ----------------
        next_cyc();
        ld_e = 1; dst_e = 5'd5; rs2_d = 5'd5; use_rs2_d = 1; #1;
        chk_ctl("lu_rs2_hit", 7'b1100_010);
        next_cyc();
        dst_e = 5'd0; rs2_d = 5'd0; #1;
        chk_ctl("lu_x0_nohit", 7'b0000_000);
        chk("lu_cnt", {32'd0, stall_cycles}, 64'd1);
        next_cyc();
        dst_e = 5'd9; rs1_d = 5'd9; use_rs1_d = 0; use_rs2_d = 0; #1;
        chk_ctl("lu_rs1_unused", 7'b0000_000);

        // ---------------- branch, no fetch in flight ----------------
        next_cyc(); idle_inputs();
        branch_taken_e = 1; redirect_pc_e = 64'h8000_0100; #1;
        chk_ctl("br_now_ctl", 7'b0000_111);
        chk("br_now_rpc", redirect_pc, 64'h8000_0100);
        next_cyc(); idle_inputs(); #1;
        chk_ctl("br_now_after", 7'b0000_000);

        // ---------------- Iwait only ----------------
        next_cyc(); Iwait = 1; #1;
        chk_ctl("iwait_only", 7'b1100_010);

        // ---------------- reset mid-redirect ----------------
        next_cyc(); branch_taken_e = 1; redirect_pc_e = 64'h8000_0F00; #1;
        chk_ctl("mid_br_enter", 7'b1000_110);
        next_cyc(); branch_taken_e = 0; Iwait = 0; reset = 1; #1;
        chk("mid_rst_drop", {63'd0, drop_ifetch}, 64'd0);
        chk_ctl("mid_rst_ctl", 7'b0000_110);
        next_cyc(); reset = 0; #1;
        chk_ctl("mid_rst_after", 7'b0000_000);
        chk("mid_rst_rpc", redirect_pc, 64'h8000_0000);
        chk("mid_rst_cnt", {32'd0, stall_cycles}, 64'd0);

        // ---------------- branch deferred behind fetch ----------------
        next_cyc(); Iwait = 1; branch_taken_e = 1; redirect_pc_e = 64'h8000_0200; #1;
        chk_ctl("def_c1", 7'b1000_110);
        next_cyc(); redirect_pc_e = 64'h8000_0300; #1;   // branch ignored in RWAIT
        chk_ctl("def_c2", 7'b1000_100);
        chk("def_c2_drop", {63'd0, drop_ifetch}, 64'd0);
        next_cyc(); branch_taken_e = 0; #1;
        chk_ctl("def_c3", 7'b1000_100);
        next_cyc(); Iwait = 0; #1;
        chk_ctl("def_c4", 7'b1000_100);
        chk("def_c4_drop", {63'd0, drop_ifetch}, 64'd1);
        next_cyc(); #1;
        chk_ctl("def_issue", 7'b0000_101);
        chk("def_issue_rpc", redirect_pc, 64'h8000_0200);
        chk("def_issue_drop", {63'd0, drop_ifetch}, 64'd0);
        chk("def_cnt", {32'd0, stall_cycles}, 64'd4);
        next_cyc(); #1;
        chk_ctl("def_done", 7'b0000_000);

        // ---------------- Dwait beats branch and load-use ----------------
        next_cyc();
        Dwait = 1; branch_taken_e = 1; redirect_pc_e = 64'h8000_0400;
        ld_e = 1; dst_e = 5'd7; rs1_d = 5'd7; use_rs1_d = 1; #1;
        chk_ctl("dw_all", 7'b1111_000);
        next_cyc(); Dwait = 0; #1;
        chk_ctl("dw_release", 7'b0000_111);
        chk("dw_release_rpc", redirect_pc, 64'h8000_0400);

        // ---------------- RISSUE held by Dwait ----------------
        next_cyc(); idle_inputs();
        Iwait = 1; branch_taken_e = 1; redirect_pc_e = 64'h8000_0500; #1;
        chk_ctl("ri_enter", 7'b1000_110);
        next_cyc(); branch_taken_e = 0; Iwait = 0; Dwait = 1; #1;
        chk_ctl("ri_rwait_dw", 7'b1111_100);
        chk("ri_drop", {63'd0, drop_ifetch}, 64'd1);
        next_cyc(); #1;
        chk_ctl("ri_hold", 7'b0111_101);
        chk("ri_hold_rpc", redirect_pc, 64'h8000_0500);
        next_cyc(); Dwait = 0; #1;
        chk_ctl("ri_go", 7'b0000_101);
        next_cyc(); #1;
        chk_ctl("ri_run", 7'b0000_000);

        // ---------------- counter saturation (2-bit instance) ----------------
        next_cyc(); idle_inputs(); reset = 1;
        next_cyc(); reset = 0; #1;
        chk("sat_start", {62'd0, s_stall_cycles}, 64'd0);
        Iwait = 1;
        next_cyc(); #1;
        chk("sat_1", {62'd0, s_stall_cycles}, 64'd1);
        next_cyc(); #1;
        chk("sat_2", {62'd0, s_stall_cycles}, 64'd2);
        next_cyc(); #1;
        chk("sat_3", {62'd0, s_stall_cycles}, 64'd3);
        next_cyc(); #1;
        chk("sat_hold", {62'd0, s_stall_cycles}, 64'd3);
        next_cyc(); #1;
        chk("sat_hold2", {62'd0, s_stall_cycles}, 64'd3);
        chk("wide_cnt", {32'd0, stall_cycles}, 64'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
